rr_one_hot_arbiter: RTL and testbench

//   Round-robin arbiter that shares one resource between NUM_REQ requesters.
//   It picks one requester and holds the grant until that requester signals

---
 rtl/rr_one_hot_arbiter_if.sv | 31 +++
 rtl/rr_one_hot_arbiter.sv | 128 ++++++++++++
 tb/tb_rr_one_hot_arbiter.sv | 231 +++++++++++++++++++++++
 3 files changed

// File: rtl/rr_one_hot_arbiter_if.sv
// Request/grant bundle between requesters and the round-robin arbiter.
// The master side drives requests and done; the slave side is the arbiter.
interface rr_one_hot_arbiter_if #(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = 2
);
    logic [NUM_REQ-1:0] req_i;
    logic               done_i;
    logic [NUM_REQ-1:0] gnt_o;
    logic [IDX_W-1:0]   gnt_idx_o;
    logic               gnt_valid_o;
    logic               timeout_o;

    modport master (
        output req_i,
        output done_i,
        input  gnt_o,
        input  gnt_idx_o,
        input  gnt_valid_o,
        input  timeout_o
    );

    modport slave (
        input  req_i,
        input  done_i,
        output gnt_o,
        output gnt_idx_o,
        output gnt_valid_o,
        output timeout_o
    );
endinterface

// File: rtl/rr_one_hot_arbiter.sv
// Round-robin arbiter: grant held until done, binary index plus one-hot.
// RR_TIMEOUT_EN adds a forced release after MAX_HOLD busy cycles.
module rr_one_hot_arbiter #(
    parameter int NUM_REQ  = 4,
    parameter int IDX_W    = 2,
    parameter int MAX_HOLD = 16
) (
    input logic                 clk,
    input logic                 reset_n,
    rr_one_hot_arbiter_if.slave arb
);

    localparam logic [IDX_W:0]   NUM_W    = (IDX_W+1)'(NUM_REQ);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_REQ - 1);

    if (IDX_W != $clog2(NUM_REQ) || NUM_REQ < 2 || NUM_REQ > 16 ||
        MAX_HOLD < 1) begin : g_bad_cfg
        $error("rr_one_hot_arbiter: illegal parameter set");
    end

    typedef enum logic {
        IDLE,
        BUSY
    } state_t;

    state_t state_q, state_d;

    logic [IDX_W-1:0]   ptr_q, ptr_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [NUM_REQ-1:0] rot;
    logic [IDX_W:0]     off;
    logic [IDX_W:0]     sum;
    logic               win_vld;
    logic [IDX_W-1:0]   win_idx;
    logic               force_hit;
    logic [IDX_W-1:0]   ptr_adv;

    // Rotate so bit i is requester (ptr+i) mod NUM_REQ; lowest set bit wins.
    always_comb begin
        rot     = NUM_REQ'({arb.req_i, arb.req_i} >> ptr_q);
        win_vld = 1'b0;
        off     = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (rot[i]) begin
                win_vld = 1'b1;
                off     = (IDX_W+1)'(i);
            end
        end
        sum     = {1'b0, ptr_q} + off;
        win_idx = (sum >= NUM_W) ? IDX_W'(sum - NUM_W) : IDX_W'(sum);
    end

    assign ptr_adv = (idx_q == LAST_IDX) ? '0 : idx_q + 1'b1;

`ifdef RR_TIMEOUT_EN
    localparam int HOLD_W = $clog2(MAX_HOLD + 1);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MAX_HOLD - 1);

    logic [HOLD_W-1:0] hold_q;
    logic              tmo_q;

    // A done on the limit edge wins; only an unanswered limit forces release.
    assign force_hit = (state_q == BUSY) && !arb.done_i &&
                       (hold_q == HOLD_LAST);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            hold_q <= '0;
            tmo_q  <= 1'b0;
        end else begin
            tmo_q <= force_hit;
            if (state_q == IDLE) begin
                hold_q <= '0;
            end else begin
                hold_q <= hold_q + 1'b1;
            end
        end
    end

    assign arb.timeout_o = tmo_q;
`else
    assign force_hit     = 1'b0;
    assign arb.timeout_o = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        idx_d   = idx_q;
        unique case (state_q)
            IDLE: begin
                if (win_vld) begin
                    state_d = BUSY;
                    idx_d   = win_idx;
                end
            end
            BUSY: begin
                if (arb.done_i || force_hit) begin
                    state_d = IDLE;
                    ptr_d   = ptr_adv;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            idx_q   <= idx_d;
        end
    end

    assign arb.gnt_valid_o = (state_q == BUSY);
    assign arb.gnt_idx_o   = idx_q;

    always_comb begin
        arb.gnt_o = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            arb.gnt_o[k] = (state_q == BUSY) && (idx_q == IDX_W'(k));
        end
    end

endmodule

// File: tb/tb_rr_one_hot_arbiter.sv
// Directed bench for rr_one_hot_arbiter: 4- and 3-requester instances.
// Timeout expectations follow RR_TIMEOUT_EN when the bench is built with it.
module tb_rr_one_hot_arbiter;

    logic clk = 1'b0;
    logic reset_n;
    int   errs   = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    rr_one_hot_arbiter_if #(.NUM_REQ(4), .IDX_W(2)) a4 ();
    rr_one_hot_arbiter_if #(.NUM_REQ(3), .IDX_W(2)) a3 ();

    rr_one_hot_arbiter #(
        .NUM_REQ (4),
        .IDX_W   (2),
        .MAX_HOLD(4)
    ) u4 (
        .clk    (clk),
        .reset_n(reset_n),
        .arb    (a4.slave)
    );

    rr_one_hot_arbiter #(
        .NUM_REQ (3),
        .IDX_W   (2),
        .MAX_HOLD(4)
    ) u3 (
        .clk    (clk),
        .reset_n(reset_n),
        .arb    (a3.slave)
    );

    task automatic check(input string tag, input logic [15:0] got,
                         input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic chk_gnt(input string tag, input logic vld,
                           input logic [1:0] idx);
        logic [3:0] exp_gnt;
        exp_gnt = vld ? 4'(1 << idx) : 4'b0;
        check({tag, ".vld"}, 16'(a4.gnt_valid_o), 16'(vld));
        check({tag, ".idx"}, 16'(a4.gnt_idx_o), 16'(idx));
        check({tag, ".gnt"}, 16'(a4.gnt_o), 16'(exp_gnt));
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset_n   = 1'b0;
        a4.req_i  = '0;
        a4.done_i = 1'b0;
        a3.req_i  = '0;
        a3.done_i = 1'b0;
        tick();
        tick();
        reset_n = 1'b1;
        tick();
    endtask

    int order[5] = '{0, 1, 2, 3, 0};

    initial begin
        reset_n   = 1'b0;
        a4.req_i  = '0;
        a4.done_i = 1'b0;
        a3.req_i  = '0;
        a3.done_i = 1'b0;

        do_reset();
        chk_gnt("rst", 1'b0, 2'd0);
        check("rst.tmo", 16'(a4.timeout_o), 16'd0);

        // single requester, done after three cycles
        a4.req_i = 4'b0001;
        tick();
        chk_gnt("t2.c0", 1'b1, 2'd0);
        tick();
        chk_gnt("t2.c1", 1'b1, 2'd0);
        tick();
        chk_gnt("t2.c2", 1'b1, 2'd0);
        a4.done_i = 1'b1;
        a4.req_i  = '0;
        tick();
        chk_gnt("t2.rel", 1'b0, 2'd0);
        a4.done_i = 1'b0;
        a4.req_i  = 4'b1001;
        tick();
        chk_gnt("t2.ptr1", 1'b1, 2'd3);
        a4.done_i = 1'b1;
        a4.req_i  = '0;
        tick();
        a4.done_i = 1'b0;

        // all requesting: strict rotation with an idle cycle between grants
        do_reset();
        a4.req_i = 4'b1111;
        foreach (order[i]) begin
            tick();
            chk_gnt("t3.gnt", 1'b1, 2'(order[i]));
            a4.done_i = 1'b1;
            tick();
            chk_gnt("t3.idle", 1'b0, 2'(order[i]));
            a4.done_i = 1'b0;
        end

        // pointer wrap and owner dropping its request mid-grant
        do_reset();
        a4.req_i = 4'b0010;
        tick();
        chk_gnt("t4.g1", 1'b1, 2'd1);
        a4.done_i = 1'b1;
        tick();
        chk_gnt("t4.i1", 1'b0, 2'd1);
        a4.done_i = 1'b0;
        a4.req_i  = 4'b0011;
        tick();
        chk_gnt("t4.wrap", 1'b1, 2'd0);
        a4.req_i = 4'b0010;
        tick();
        chk_gnt("t4.drop0", 1'b1, 2'd0);
        tick();
        chk_gnt("t4.drop1", 1'b1, 2'd0);
        a4.done_i = 1'b1;
        tick();
        chk_gnt("t4.i0", 1'b0, 2'd0);
        a4.done_i = 1'b0;
        tick();
        chk_gnt("t4.next", 1'b1, 2'd1);
        a4.done_i = 1'b1;
        a4.req_i  = '0;
        tick();
        a4.done_i = 1'b0;

        // done ignored while idle, then async reset mid-grant
        do_reset();
        a4.done_i = 1'b1;
        tick();
        chk_gnt("t1.idle_done", 1'b0, 2'd0);
        a4.req_i = 4'b0100;
        tick();
        chk_gnt("t1.grant", 1'b1, 2'd2);
        a4.done_i = 1'b0;
        a4.req_i  = '0;
        tick();
        #2;
        reset_n = 1'b0;
        #1;
        chk_gnt("t1.async", 1'b0, 2'd0);
        tick();
        reset_n  = 1'b1;
        a4.req_i = 4'b0100;
        tick();
        chk_gnt("t1.after", 1'b1, 2'd2);
        a4.done_i = 1'b1;
        a4.req_i  = '0;
        tick();
        a4.done_i = 1'b0;

        // hold limit behaviour
        do_reset();
        a4.req_i = 4'b1000;
        tick();
        chk_gnt("t6.e0", 1'b1, 2'd3);
        check("t6.e0.tmo", 16'(a4.timeout_o), 16'd0);
        for (int c = 1; c < 4; c++) begin
            tick();
            chk_gnt("t6.hold", 1'b1, 2'd3);
        end
        tick();
`ifdef RR_TIMEOUT_EN
        chk_gnt("t6.forced", 1'b0, 2'd3);
        check("t6.tmo_pulse", 16'(a4.timeout_o), 16'd1);
        a4.req_i = 4'b1001;
        tick();
        chk_gnt("t6.ptr0", 1'b1, 2'd0);
        check("t6.tmo_end", 16'(a4.timeout_o), 16'd0);
        for (int c = 1; c < 4; c++) begin
            tick();
            chk_gnt("t6.hold2", 1'b1, 2'd0);
        end
        a4.done_i = 1'b1;
        tick();
        chk_gnt("t6.done_lim", 1'b0, 2'd0);
        check("t6.done_tmo", 16'(a4.timeout_o), 16'd0);
`else
        chk_gnt("t6.kept", 1'b1, 2'd3);
        check("t6.tmo0", 16'(a4.timeout_o), 16'd0);
        tick();
        chk_gnt("t6.kept2", 1'b1, 2'd3);
        check("t6.tmo1", 16'(a4.timeout_o), 16'd0);
        a4.done_i = 1'b1;
        tick();
        chk_gnt("t6.rel", 1'b0, 2'd3);
        check("t6.tmo2", 16'(a4.timeout_o), 16'd0);
`endif
        a4.done_i = 1'b0;
        a4.req_i  = '0;

        // three requesters: pointer wraps at 3
        do_reset();
        a3.req_i = 3'b100;
        tick();
        check("t5.vld", 16'(a3.gnt_valid_o), 16'd1);
        check("t5.idx2", 16'(a3.gnt_idx_o), 16'd2);
        check("t5.gnt2", 16'(a3.gnt_o), 16'b100);
        a3.done_i = 1'b1;
        a3.req_i  = '0;
        tick();
        check("t5.idle", 16'(a3.gnt_valid_o), 16'd0);
        check("t5.idle_gnt", 16'(a3.gnt_o), 16'd0);
        a3.done_i = 1'b0;
        a3.req_i  = 3'b111;
        tick();
        check("t5.wrap_idx", 16'(a3.gnt_idx_o), 16'd0);
        check("t5.wrap_gnt", 16'(a3.gnt_o), 16'b001);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
